// File: rtl/iter_normalizer.sv
// Iterative floating-point mantissa normaliser: left-shifts up to STEP bits per cycle until the hidden bit is set.
// Define ITER_NORMALIZER_DENORM_EN to keep gradually-denormalised mantissas on underflow instead of flushing to zero.
module iter_normalizer #(
    parameter int X         = 32,
    parameter int expo_bits = 8,
    parameter int STEP      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [X-expo_bits:0] mant_in,
    input  logic [expo_bits-1:0] exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [X-expo_bits:0] mant_out,
    output logic [expo_bits-1:0] exp_out,
    output logic                 zero_out,
    output logic                 ovf_out,
    output logic                 unf_out,
    output logic                 busy
);

    localparam int M  = X - expo_bits + 1;
    localparam int EW = expo_bits;
    localparam int KW = $clog2(STEP + 1);
    localparam int CW = ((EW > KW) ? EW : KW) + 1;

    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0] EXP_OVF = {{(EW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_reg;
    logic [M-1:0]  mant_reg;
    logic [EW-1:0] exp_reg;

    // zpre[gi] is set when the gi+1 bits from the hidden position downwards are all zero.
    logic [STEP-1:0] zpre;
    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_zpre
            assign zpre[gi] = ~|mant_reg[M-2 -: gi+1];
        end
    endgenerate

    logic [KW-1:0] lz_k;
    always_comb begin
        lz_k = '0;
        for (int i = 0; i < STEP; i++) begin
            lz_k = lz_k + KW'(zpre[i]);
        end
    end

    // The per-cycle shift is limited so the exponent never drops below 1.
    logic [CW-1:0] room;
    logic [CW-1:0] lz_c;
    logic [CW-1:0] k;
    logic [M-1:0]  mant_sh;
    logic [EW-1:0] exp_sh;

    assign room    = CW'(exp_reg) - CW'(1);
    assign lz_c    = CW'(lz_k);
    assign k       = (room < lz_c) ? room : lz_c;
    assign mant_sh = mant_reg << k;
    assign exp_sh  = exp_reg - EW'(k);

    logic          cap_done;
    logic [M-1:0]  cap_mant;
    logic [EW-1:0] cap_exp;
    logic          cap_zero;
    logic          cap_ovf;
    logic          cap_unf;

    // Classification of a freshly captured operand; cases that need no shifting finish at once.
    // A carry with an exponent already at all-ones saturates to overflow as well.
    always_comb begin
        cap_done = 1'b1;
        cap_mant = '0;
        cap_exp  = '0;
        cap_zero = 1'b0;
        cap_ovf  = 1'b0;
        cap_unf  = 1'b0;
        if (mant_in == '0) begin
            cap_zero = 1'b1;
        end else if (mant_in[M-1]) begin
            if (exp_in >= EXP_OVF) begin
                cap_exp = EXP_MAX;
                cap_ovf = 1'b1;
            end else begin
                cap_mant = mant_in >> 1;
                cap_exp  = exp_in + 1'b1;
            end
        end else if (mant_in[M-2]) begin
            cap_mant = mant_in;
            cap_exp  = exp_in;
        end else if (exp_in <= EW'(1)) begin
            cap_unf = 1'b1;
`ifdef ITER_NORMALIZER_DENORM_EN
            cap_mant = mant_in;
`else
            cap_mant = '0;
`endif
        end else begin
            cap_done = 1'b0;
        end
    end

    logic          step_done;
    logic [M-1:0]  step_mant;
    logic [EW-1:0] step_exp;
    logic          step_unf;

    always_comb begin
        step_done = 1'b0;
        step_mant = '0;
        step_exp  = '0;
        step_unf  = 1'b0;
        if (mant_sh[M-2]) begin
            step_done = 1'b1;
            step_mant = mant_sh;
            step_exp  = exp_sh;
        end else if (exp_sh == EW'(1)) begin
            step_done = 1'b1;
            step_unf  = 1'b1;
`ifdef ITER_NORMALIZER_DENORM_EN
            step_mant = mant_sh;
`else
            step_mant = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mant_reg  <= '0;
            exp_reg   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mant_out  <= '0;
            exp_out   <= '0;
            zero_out  <= 1'b0;
            ovf_out   <= 1'b0;
            unf_out   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        mant_reg <= mant_in;
                        exp_reg  <= exp_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (cap_done) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            mant_out  <= cap_mant;
                            exp_out   <= cap_exp;
                            zero_out  <= cap_zero;
                            ovf_out   <= cap_ovf;
                            unf_out   <= cap_unf;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant_reg <= mant_sh;
                    exp_reg  <= exp_sh;
                    if (step_done) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        mant_out  <= step_mant;
                        exp_out   <= step_exp;
                        zero_out  <= 1'b0;
                        ovf_out   <= 1'b0;
                        unf_out   <= step_unf;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        mant_out  <= '0;
                        exp_out   <= '0;
                        zero_out  <= 1'b0;
                        ovf_out   <= 1'b0;
                        unf_out   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_normalizer.sv
// Self-checking bench for iter_normalizer: directed vector table, handshake/reset sequences and random operands.
module tb_iter_normalizer;

    localparam int X    = 32;
    localparam int EB   = 8;
    localparam int STEP = 4;
    localparam int M    = X - EB + 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [M-1:0]  mant_in   = '0;
    logic [EB-1:0] exp_in    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [M-1:0]  mant_out;
    logic [EB-1:0] exp_out;
    logic          zero_out;
    logic          ovf_out;
    logic          unf_out;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iter_normalizer #(.X(X), .expo_bits(EB), .STEP(STEP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mant_in  (mant_in),
        .exp_in   (exp_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mant_out (mant_out),
        .exp_out  (exp_out),
        .zero_out (zero_out),
        .ovf_out  (ovf_out),
        .unf_out  (unf_out),
        .busy     (busy)
    );

    typedef struct {
        logic [M-1:0]  mant;
        logic [EB-1:0] expo;
        int            stall;
        logic [M-1:0]  r_mant;
        logic [EB-1:0] r_exp;
        logic          r_zero;
        logic          r_ovf;
        logic          r_unf;
        int            lat;
        bit            exact;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: find the leading one, shift it to the hidden position in one go, and
    // derive the cycle count from how many STEP-sized chunks that distance needs.
    function automatic void ref_model(input logic [M-1:0] m, input logic [EB-1:0] e,
                                      output logic [M-1:0] rm, output logic [EB-1:0] re,
                                      output logic rz, output logic ro, output logic ru,
                                      output int lat, output bit exact);
        int top, lz, s, ei;
        rm = '0; re = '0; rz = 0; ro = 0; ru = 0; lat = 1; exact = 1;
        ei = int'(e);
        if (m == '0) begin
            rz = 1;
        end else if (m[M-1]) begin
            if (ei + 1 >= (1 << EB) - 1) begin
                re = '1;
                ro = 1;
            end else begin
                rm = m >> 1;
                re = e + 1'b1;
            end
        end else if (m[M-2]) begin
            rm = m;
            re = e;
        end else begin
            top = 0;
            for (int i = 0; i < M; i++) if (m[i]) top = i;
            lz = (M - 2) - top;
            if (lz < ei) begin
                rm  = m << lz;
                re  = EB'(ei - lz);
                lat = 1 + (lz + STEP - 1) / STEP;
            end else begin
                ru = 1;
                s  = (ei > 0) ? ei - 1 : 0;
`ifdef ITER_NORMALIZER_DENORM_EN
                rm  = m << s;
                lat = 1 + (s + STEP - 1) / STEP;
`else
                exact = 0;
                lat   = 1 + (lz + STEP - 1) / STEP;
`endif
            end
        end
    endfunction

    task automatic run_op(input string tag, input vec_t v, input bit hold_valid);
        int w, j;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        if (in_ready) begin
            mant_in   = v.mant;
            exp_in    = v.expo;
            in_valid  = 1'b1;
            out_ready = (v.stall == 0);
            tick();
            if (!hold_valid) in_valid = 1'b0;
            j = 0;
            while (!out_valid && j < 64) begin
                check({tag, ".shift"}, 32'({busy, in_ready, zero_out, ovf_out, unf_out, |mant_out, |exp_out}),
                      32'b1000000);
                tick();
                j++;
            end
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            if (v.exact) check({tag, ".latency"}, 32'(j + 1), 32'(v.lat));
            else         check({tag, ".latency_bound"}, 32'(j + 1 <= v.lat), 32'd1);
            check({tag, ".mant"}, 32'(mant_out), 32'(v.r_mant));
            check({tag, ".exp"}, 32'(exp_out), 32'(v.r_exp));
            check({tag, ".flags"}, 32'({zero_out, ovf_out, unf_out, in_ready, busy}),
                  32'({v.r_zero, v.r_ovf, v.r_unf, 1'b0, 1'b1}));
            for (int s = 0; s < v.stall; s++) begin
                tick();
                check({tag, ".hold"}, 32'({out_valid, in_ready, zero_out, ovf_out, unf_out}),
                      32'({1'b1, 1'b0, v.r_zero, v.r_ovf, v.r_unf}));
                check({tag, ".hold_mant"}, 32'(mant_out), 32'(v.r_mant));
                check({tag, ".hold_exp"}, 32'(exp_out), 32'(v.r_exp));
            end
            out_ready = 1'b1;
            tick();
            check({tag, ".release"}, 32'({out_valid, busy, in_ready, zero_out, ovf_out, unf_out, |mant_out, |exp_out}),
                  32'b00100000);
            in_valid = 1'b0;
            $display("op %s mant=%h exp=%0d -> mant=%h exp=%0d z=%0d o=%0d u=%0d lat=%0d",
                     tag, v.mant, v.expo, v.r_mant, v.r_exp, v.r_zero, v.r_ovf, v.r_unf, j + 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[13];
        vec_t rv;
        int w;
        int seen;

        vt[0]  = '{25'h0000001, 8'd100, 0, 25'h0800000, 8'd77,  1'b0, 1'b0, 1'b0, 7, 1'b1};
        vt[1]  = '{25'h1800000, 8'd10,  0, 25'h0C00000, 8'd11,  1'b0, 1'b0, 1'b0, 1, 1'b1};
        vt[2]  = '{25'h1000000, 8'd254, 0, 25'h0000000, 8'd255, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        vt[3]  = '{25'h0000000, 8'd50,  0, 25'h0000000, 8'd0,   1'b1, 1'b0, 1'b0, 1, 1'b1};
`ifdef ITER_NORMALIZER_DENORM_EN
        vt[4]  = '{25'h0000100, 8'd5,   0, 25'h0001000, 8'd0,   1'b0, 1'b0, 1'b1, 2, 1'b1};
        vt[8]  = '{25'h0010000, 8'd7,   0, 25'h0400000, 8'd0,   1'b0, 1'b0, 1'b1, 3, 1'b1};
        vt[9]  = '{25'h0000003, 8'd1,   0, 25'h0000003, 8'd0,   1'b0, 1'b0, 1'b1, 1, 1'b1};
`else
        vt[4]  = '{25'h0000100, 8'd5,   0, 25'h0000000, 8'd0,   1'b0, 1'b0, 1'b1, 5, 1'b0};
        vt[8]  = '{25'h0010000, 8'd7,   0, 25'h0000000, 8'd0,   1'b0, 1'b0, 1'b1, 3, 1'b0};
        vt[9]  = '{25'h0000003, 8'd1,   0, 25'h0000000, 8'd0,   1'b0, 1'b0, 1'b1, 7, 1'b0};
`endif
        vt[5]  = '{25'h0ABCDEF, 8'd130, 0, 25'h0ABCDEF, 8'd130, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        vt[6]  = '{25'h0400000, 8'd3,   0, 25'h0800000, 8'd2,   1'b0, 1'b0, 1'b0, 2, 1'b1};
        vt[7]  = '{25'h0010000, 8'd8,   0, 25'h0800000, 8'd1,   1'b0, 1'b0, 1'b0, 3, 1'b1};
        vt[10] = '{25'h1FFFFFF, 8'd253, 0, 25'h0FFFFFF, 8'd254, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        vt[11] = '{25'h0700000, 8'd40,  0, 25'h0E00000, 8'd39,  1'b0, 1'b0, 1'b0, 2, 1'b1};
        vt[12] = '{25'h0000001, 8'd100, 3, 25'h0800000, 8'd77,  1'b0, 1'b0, 1'b0, 7, 1'b1};

        // Reset with in_valid asserted: nothing may be captured.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mant_in  = 25'h0800000;
        exp_in   = 8'd9;
        repeat (3) tick();
        check("reset.state", 32'({out_valid, busy, in_ready, zero_out, ovf_out, unf_out, |mant_out, |exp_out}), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("reset.release", 32'({in_ready, busy, out_valid}), 32'b100);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vt[i], vt[i].stall > 0);
        end

        // Reset while the slow operand is mid-SHIFT; it must never produce a result.
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        mant_in  = 25'h0000001;
        exp_in   = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst.shifting", 32'({busy, out_valid}), 32'b10);
        rst_n = 1'b0;
        tick();
        check("midrst.idle", 32'({out_valid, busy, in_ready, |mant_out, |exp_out}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid || busy) seen++;
        end
        check("midrst.no_output", 32'(seen), 32'd0);
        run_op("after_rst", vt[0], 1'b0);

        for (int i = 0; i < 150; i++) begin
            int unsigned r;
            int sel;
            r   = $urandom;
            sel = $urandom_range(0, 9);
            rv.mant = M'(r) & {1'b0, {(M-1){1'b1}}};
            rv.mant = rv.mant >> $urandom_range(0, M - 2);
            if (rv.mant == '0) rv.mant = 1;
            if (sel == 0) rv.mant = '0;
            if (sel == 1) rv.mant[M-1] = 1'b1;
            if (sel == 2) rv.mant[M-2] = 1'b1;
            rv.expo = (sel % 2 == 0) ? EB'($urandom_range(0, 30)) : EB'($urandom_range(0, 255));
            if (rv.mant[M-1] && rv.expo == 8'd255) rv.expo = 8'd254;
            rv.stall = $urandom_range(0, 2);
            ref_model(rv.mant, rv.expo, rv.r_mant, rv.r_exp, rv.r_zero, rv.r_ovf, rv.r_unf, rv.lat, rv.exact);
            run_op($sformatf("rnd%0d", i), rv, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
